// File: rtl/dwt_downsample_if.sv
// dwt_downsample_if: sample stream in, decimated FIFO stream out; slave = dwt_downsample side, master = producer/consumer side
interface dwt_downsample_if #(
  parameter int W_IN  = 20,
  parameter int W_OUT = 16,
  parameter int DEPTH = 4
);
  logic                       in_valid;
  logic signed [W_IN-1:0]     in_data;
  logic                       frame_start;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [W_OUT-1:0]    out_data;
  logic [$clog2(DEPTH):0]     fifo_count;
  logic                       ovf;
  logic                       ovf_clr;
  modport slave (
    input  in_valid, in_data, frame_start, out_ready, ovf_clr,
    output out_valid, out_data, fifo_count, ovf
  );
  modport master (
    output in_valid, in_data, frame_start, out_ready, ovf_clr,
    input  out_valid, out_data, fifo_count, ovf
  );
endinterface

// File: rtl/dwt_downsample.sv
// dwt_downsample: decimate-by-2, round/shift to W_OUT, FIFO behind valid/ready; ports clk, rstn (sync active-low), bus (slave); DWT_SAT_EN selects saturation instead of wrap
module dwt_downsample #(
  parameter int W_IN  = 20,
  parameter int W_OUT = 16,
  parameter int SHIFT = 4,
  parameter int DEPTH = 4,
  parameter int PHASE = 0
) (
  input logic clk,
  input logic rstn,
  dwt_downsample_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic signed [W_IN:0] RND = (W_IN+1)'(1 << (SHIFT-1));
  logic [W_OUT-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic phase, ovf, cur_phase, keep, pop, push;
  logic signed [W_IN:0] t;
  logic [W_OUT-1:0] res;
  assign t = {bus.in_data[W_IN-1], bus.in_data} + RND;
`ifdef DWT_SAT_EN
  localparam logic signed [W_IN:0] MAXV = (W_IN+1)'((1 << (W_OUT-1)) - 1);
  localparam logic signed [W_IN:0] MINV = ~MAXV;
  logic signed [W_IN:0] sh;
  assign sh = t >>> SHIFT;
  assign res = sh > MAXV ? W_OUT'(MAXV) : sh < MINV ? W_OUT'(MINV) : W_OUT'(sh);
`else
  assign res = W_OUT'(t >>> SHIFT);
`endif
  // frame_start forces the current sample to phase 0 regardless of history
  assign cur_phase = bus.frame_start ? 1'b0 : phase;
  assign keep = bus.in_valid && (cur_phase == 1'(PHASE));
  assign pop = (count != '0) && bus.out_ready;
  // a full FIFO still accepts when the head leaves on the same edge
  assign push = keep && ((count != CW'(DEPTH)) || pop);
  always_ff @(posedge clk) begin
    if (!rstn) begin
      phase <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      ovf <= 1'b0;
    end else begin
      if (bus.in_valid) phase <= ~cur_phase;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      ovf <= (keep && !push) || (ovf && !bus.ovf_clr);
    end
  end
  always_ff @(posedge clk)
    if (rstn && push) mem[wr_ptr] <= res;
  assign bus.out_valid = count != '0;
  assign bus.out_data = bus.out_valid ? mem[rd_ptr] : '0;
  assign bus.fifo_count = count;
  assign bus.ovf = ovf;
endmodule
